// File: rtl/bus_sched_pkg.sv
// Shared types, constants and helpers for the round-robin bus scheduler.
package bus_sched_pkg;

  localparam int unsigned ID_W      = 8;
  localparam int unsigned PKT_MAX_W = 256;

  localparam logic [ID_W-1:0] BCAST_DEFAULT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    SEND
  } state_e;

  // How the packet currently held by the scheduler is to be delivered.
  typedef enum logic [1:0] {
    K_UNI,
    K_BCAST,
    K_DROP
  } kind_e;

  // Destination ID sits in the top ID_W bits of a pkt_w-bit packet.
  function automatic logic [ID_W-1:0] dest_id(input logic [PKT_MAX_W-1:0] pkt,
                                              input int unsigned          pkt_w);
    return ID_W'(pkt >> (pkt_w - ID_W));
  endfunction

endpackage

// File: rtl/bus_rr_scheduler_if.sv
// Scheduler bus: source-FIFO heads, destination-FIFO strobes and status.
interface bus_rr_scheduler_if #(
  parameter int unsigned pckg_sz = 16,
  parameter int unsigned drvrs   = 4
);

  localparam int unsigned GRANT_W = $clog2(drvrs);

  logic [drvrs-1:0]              pndng;
  logic [drvrs-1:0][pckg_sz-1:0] D_pop;
  logic [drvrs-1:0]              full;
  logic [drvrs-1:0]              pop;
  logic [drvrs-1:0]              push;
  logic [drvrs-1:0][pckg_sz-1:0] D_push;
  logic [GRANT_W-1:0]            grant;
  logic                          busy;
  logic [7:0]                    err_cnt;

  modport master (
    output pndng, D_pop, full,
    input  pop, push, D_push, grant, busy, err_cnt
  );

  modport slave (
    input  pndng, D_pop, full,
    output pop, push, D_push, grant, busy, err_cnt
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin search: first requester at or after ptr, wrapping modulo n.
module rr_picker #(
  parameter int unsigned n = 4,
  localparam int unsigned W = $clog2(n)
) (
  input  logic [n-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner_c,
  output logic         valid_c
);

  int unsigned idx;

  always_comb begin
    winner_c = '0;
    valid_c  = 1'b0;
    idx      = 0;
    for (int unsigned i = 0; i < n; i++) begin
      idx = (32'(ptr) + i) % n;
      if (!valid_c && req[W'(idx)]) begin
        valid_c  = 1'b1;
        winner_c = W'(idx);
      end
    end
  end

endmodule

// File: rtl/bus_rr_scheduler.sv
// Round-robin scheduler moving one packet at a time from source FIFOs to destination FIFOs.
// Define BUS_BCAST_EN to deliver broadcast-addressed packets to every other driver.
module bus_rr_scheduler
  import bus_sched_pkg::*;
#(
  parameter int unsigned     pckg_sz   = 16,
  parameter int unsigned     drvrs     = 4,
  parameter logic [ID_W-1:0] broadcast = BCAST_DEFAULT
) (
  input logic               clk,
  input logic               reset,
  bus_rr_scheduler_if.slave bus
);

  localparam int unsigned      GW    = $clog2(drvrs);
  localparam logic [drvrs-1:0] LANE0 = {{(drvrs-1){1'b0}}, 1'b1};

  state_e             state, state_nxt;
  logic [GW-1:0]      grant_q, grant_nxt;
  logic [GW-1:0]      rr_ptr, rr_nxt;
  logic [GW-1:0]      winner_c;
  logic               valid_c;
  logic [drvrs-1:0]   pop_q, pop_nxt;
  logic [drvrs-1:0]   push_q, push_nxt;
  logic [pckg_sz-1:0] pkt_q, pkt_nxt;
  logic [pckg_sz-1:0] d_push_q, d_push_nxt;
  logic [7:0]         err_q, err_nxt;
  logic               busy_q, busy_nxt;

  logic [pckg_sz-1:0] cur_pkt_c;
  logic [ID_W-1:0]    dest_c;
  kind_e              kind_c;
  logic               ready_c;
  logic [drvrs-1:0]   push_vec_c;
`ifdef BUS_BCAST_EN
  logic [drvrs-1:0]   others_c;
`endif

  rr_picker #(.n(drvrs)) u_picker (
    .req      (bus.pndng),
    .ptr      (rr_ptr),
    .winner_c (winner_c),
    .valid_c  (valid_c)
  );

  // Classify the packet in flight: the FIFO head while popping, the latched copy afterwards.
  always_comb begin
    cur_pkt_c  = (state == POP) ? bus.D_pop[grant_q] : pkt_q;
    dest_c     = dest_id(PKT_MAX_W'(cur_pkt_c), pckg_sz);
    kind_c     = K_DROP;
    ready_c    = 1'b0;
    push_vec_c = '0;
`ifdef BUS_BCAST_EN
    others_c   = ~(LANE0 << grant_q);
`endif
    if (dest_c == broadcast) begin
`ifdef BUS_BCAST_EN
      kind_c     = K_BCAST;
      push_vec_c = others_c;
      ready_c    = ((bus.full & others_c) == '0);
`endif
    end else if (32'(dest_c) < drvrs && 32'(dest_c) != 32'(grant_q)) begin
      kind_c     = K_UNI;
      push_vec_c = LANE0 << dest_c[GW-1:0];
      ready_c    = !bus.full[dest_c[GW-1:0]];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant_q;
    rr_nxt     = rr_ptr;
    pop_nxt    = '0;
    push_nxt   = '0;
    pkt_nxt    = pkt_q;
    d_push_nxt = d_push_q;
    err_nxt    = err_q;
    case (state)
      IDLE: begin
        if (valid_c) begin
          grant_nxt = winner_c;
          pop_nxt   = LANE0 << winner_c;
          state_nxt = POP;
        end
      end
      POP: begin
        pkt_nxt    = cur_pkt_c;
        d_push_nxt = cur_pkt_c;
        state_nxt  = SEND;
        if (kind_c != K_DROP && ready_c) push_nxt = push_vec_c;
      end
      SEND: begin
        // Leave after the push cycle, or straight away for a dropped packet.
        if (push_q != '0 || kind_c == K_DROP) begin
          state_nxt = IDLE;
          rr_nxt    = (32'(grant_q) == drvrs - 1) ? '0 : GW'(grant_q + 1'b1);
          if (push_q == '0 && err_q != 8'hFF) err_nxt = err_q + 8'd1;
        end else if (ready_c) begin
          push_nxt = push_vec_c;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant_q  <= '0;
      rr_ptr   <= '0;
      pop_q    <= '0;
      push_q   <= '0;
      pkt_q    <= '0;
      d_push_q <= '0;
      err_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant_q  <= grant_nxt;
      rr_ptr   <= rr_nxt;
      pop_q    <= pop_nxt;
      push_q   <= push_nxt;
      pkt_q    <= pkt_nxt;
      d_push_q <= d_push_nxt;
      err_q    <= err_nxt;
      busy_q   <= busy_nxt;
    end
  end

  assign bus.pop     = pop_q;
  assign bus.push    = push_q;
  assign bus.D_push  = {drvrs{d_push_q}};
  assign bus.grant   = grant_q;
  assign bus.busy    = busy_q;
  assign bus.err_cnt = err_q;

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Directed bench for bus_rr_scheduler: source-FIFO model plus a pop/push scoreboard.
module tb_bus_rr_scheduler;

  localparam int unsigned PW = 16;
  localparam int unsigned ND = 4;
  localparam int unsigned IW = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bus_rr_scheduler_if #(.pckg_sz(PW), .drvrs(ND)) bus ();

  bus_rr_scheduler #(.pckg_sz(PW), .drvrs(ND)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] srcq [ND][$];
  logic [ND-1:0] pending = '0;
  int            exp_pop [$];
  logic [ND-1:0] exp_pv  [$];
  logic [PW-1:0] exp_pd  [$];

  // One full round of traffic in expected grant order; each goes to the next driver up.
  logic [PW-1:0] r31_pkt [8] = '{16'h0110, 16'h0220, 16'h0330, 16'h0040,
                                 16'h0111, 16'h0221, 16'h0331, 16'h0041};
  logic [ND-1:0] r31_pv  [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001,
                                 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit src_empty();
    bit e = 1'b1;
    for (int d = 0; d < ND; d++) if (srcq[d[IW-1:0]].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic send(input int src, input logic [PW-1:0] pkt, input logic [ND-1:0] pv);
    srcq[src[IW-1:0]].push_back(pkt);
    exp_pop.push_back(src);
    if (pv != '0) begin
      exp_pv.push_back(pv);
      exp_pd.push_back(pkt);
    end
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < max) begin
      @(negedge clk);
      n++;
      done = !bus.busy && exp_pop.size() == 0 && exp_pv.size() == 0 &&
             pending == '0 && src_empty();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s: not idle after %0d cycles", name, max);
    end
  endtask

  task automatic wait_pop(input string name, input int src, input int max);
    int n = 0;
    while (!bus.pop[src[IW-1:0]] && n < max) begin
      @(negedge clk);
      n++;
    end
    if (!bus.pop[src[IW-1:0]]) begin
      checks++;
      errors++;
      $display("FAIL %s: no pop from source %0d within %0d cycles", name, src, max);
    end
  endtask

  // Source FIFOs: a pop strobe seen in one cycle dequeues the head by the next cycle.
  always @(negedge clk) begin
    if (reset) begin
      pending = '0;
    end else begin
      for (int d = 0; d < ND; d++)
        if (pending[d[IW-1:0]] && srcq[d[IW-1:0]].size() != 0) void'(srcq[d[IW-1:0]].pop_front());
      pending = bus.pop;
    end
    for (int d = 0; d < ND; d++) begin
      bus.pndng[d[IW-1:0]] = (srcq[d[IW-1:0]].size() != 0);
      bus.D_pop[d[IW-1:0]] = (srcq[d[IW-1:0]].size() != 0) ? srcq[d[IW-1:0]][0] : '0;
    end
  end

  // Scoreboard monitor: every pop and push strobe is matched against the expected queues.
  always @(negedge clk) begin : monitor
    int            e;
    logic [ND-1:0] pv;
    logic [PW-1:0] pd;
    if (!reset) begin
      if (bus.pop != '0) begin
        if (exp_pop.size() == 0) begin
          chk("unexpected_pop", 32'(bus.pop), 0);
        end else begin
          e = exp_pop.pop_front();
          chk("pop_vec", 32'(bus.pop), 32'(1) << e);
          chk("pop_grant", 32'(bus.grant), 32'(e));
        end
      end
      if (bus.push != '0) begin
        if (exp_pv.size() == 0) begin
          chk("unexpected_push", 32'(bus.push), 0);
        end else begin
          pv = exp_pv.pop_front();
          pd = exp_pd.pop_front();
          chk("push_vec", 32'(bus.push), 32'(pv));
          chk("push_data_lane0", 32'(bus.D_push[0]), 32'(pd));
          chk("push_data_lane3", 32'(bus.D_push[ND-1]), 32'(pd));
        end
      end
    end
  end

  initial begin
    bus.full = '0;
    repeat (3) @(negedge clk);
    chk("rst_pop", 32'(bus.pop), 0);
    chk("rst_push", 32'(bus.push), 0);
    chk("rst_dpush", 32'(bus.D_push[0]), 0);
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_err", 32'(bus.err_cnt), 0);
    reset = 1'b0;

    // All four sources pending: grants must rotate 0,1,2,3,0,1,2,3.
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) send(k % ND, r31_pkt[k], r31_pv[k]);
    wait_idle("rr_round", 100);

    // Lone unicast from source 2 to driver 1 at minimum latency.
    @(posedge clk); #1;
    send(2, 16'h01AB, 4'b0010);
    @(negedge clk);
    @(negedge clk);
    chk("lat_pop", 32'(bus.pop), 32'(4'b0100));
    chk("lat_busy", 32'(bus.busy), 1);
    @(negedge clk);
    chk("lat_push", 32'(bus.push), 32'(4'b0010));
    chk("lat_dpush", 32'(bus.D_push[1]), 32'(16'h01AB));
    wait_idle("unicast", 20);
    chk("err_after_unicast", 32'(bus.err_cnt), 0);

    // Destination 3 full for five SEND cycles, push follows the release.
    @(posedge clk); #1;
    bus.full = 4'b1000;
    send(0, 16'h03CD, 4'b1000);
    @(negedge clk);
    wait_pop("full_pop", 0, 10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("full_hold_push", 32'(bus.push), 0);
      chk("full_hold_busy", 32'(bus.busy), 1);
    end
    bus.full = '0;
    @(negedge clk);
    chk("full_release_push", 32'(bus.push), 32'(4'b1000));
    chk("full_release_dpush", 32'(bus.D_push[3]), 32'(16'h03CD));
    wait_idle("full_wait", 20);

    // Self-addressed and out-of-range packets are dropped and counted.
    @(posedge clk); #1;
    send(1, 16'h0100, 4'b0000);
    send(1, 16'h0700, 4'b0000);
    wait_idle("drops", 30);
    chk("err_two_drops", 32'(bus.err_cnt), 2);

    // Broadcast from source 2.
    @(posedge clk); #1;
`ifdef BUS_BCAST_EN
    send(2, 16'hFF55, 4'b1011);
    wait_idle("bcast", 20);
    chk("err_bcast", 32'(bus.err_cnt), 2);
`else
    send(2, 16'hFF55, 4'b0000);
    wait_idle("bcast", 20);
    chk("err_bcast", 32'(bus.err_cnt), 3);
`endif

    // Reset during POP aborts the transfer and restarts the round-robin at index 0.
    @(posedge clk); #1;
    send(0, 16'h0100, 4'b0000);
    @(negedge clk);
    wait_pop("rst_mid_pop", 0, 10);
    #1 reset = 1'b1;
    #1;
    chk("midrst_pop", 32'(bus.pop), 0);
    chk("midrst_push", 32'(bus.push), 0);
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_grant", 32'(bus.grant), 0);
    chk("midrst_err", 32'(bus.err_cnt), 0);
    chk("midrst_dpush", 32'(bus.D_push[0]), 0);
    srcq[0].delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    send(1, 16'h0255, 4'b0100);
    send(3, 16'h0066, 4'b0001);
    wait_idle("after_reset", 30);

    chk("exp_pop_left", 32'(exp_pop.size()), 0);
    chk("exp_push_left", 32'(exp_pv.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_rr_scheduler.md
BUS_RR_SCHEDULER -- requirements
Module: bus_rr_scheduler

Interface
REQ-001 Parameter pckg_sz, default 16: packet width in bits; bits [pckg_sz-1:pckg_sz-8] hold the destination ID.
REQ-002 Parameter drvrs, default 4: number of driver ports (2..16).
REQ-003 Parameter broadcast, default 8'hFF: destination ID meaning "all drivers".
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 pndng  in  [drvrs-1:0]  source FIFO d holds at least one packet.
REQ-007 D_pop  in  [drvrs-1:0][pckg_sz-1:0]  head-of-FIFO data per source, valid whenever pndng[d]=1.
REQ-008 full  in  [drvrs-1:0]  destination FIFO d cannot accept a push.
REQ-009 pop  out  [drvrs-1:0]  one-cycle dequeue strobe to source d.
REQ-010 push  out  [drvrs-1:0]  one-cycle enqueue strobe to destination d.
REQ-011 D_push  out  [drvrs-1:0][pckg_sz-1:0]  outgoing packet; all lanes carry the same latched packet.
REQ-012 grant  out  [$clog2(drvrs)-1:0]  index of the current or last granted source.
REQ-013 busy  out  1  high whenever the FSM is not in IDLE.
REQ-014 err_cnt  out  8  count of dropped packets; saturates at 255.

Function
REQ-015 FSM states: IDLE, POP, SEND; state is registered.
- IDLE: when pndng is nonzero, register the round-robin winner into grant and go to POP.
- POP: assert pop[grant] for exactly one cycle, latch D_pop[grant] into pkt_q, then go to SEND.
- SEND: push, wait or drop as defined below, then return to IDLE.
REQ-016 Round-robin order: search starts at rr_ptr and wraps modulo drvrs.
- The first index with pndng=1 wins.
- rr_ptr <= (grant+1) mod drvrs when the packet leaves SEND.
REQ-017 Latency: pndng[d] high at edge k with the bus idle gives pop[d]=1 in cycle k+1 and push in cycle k+2 at the earliest.
REQ-018 Unicast: destination ID t < drvrs and t != grant.
- SEND asserts push[t] for one cycle when full[t]=0, then goes to IDLE.
- While full[t]=1 it holds SEND with push=0.
REQ-019 Drop rule: t == grant, or t >= drvrs and t != broadcast.
- The packet is dropped: no push, err_cnt increments by 1, and the FSM returns to IDLE after one SEND cycle.
REQ-020 pop and push are never asserted in the same cycle; at most one pop bit is high per cycle.
REQ-021 pndng changes during POP/SEND do not affect the current transfer.
REQ-022 D_push holds pkt_q during SEND and keeps its last value otherwise.
REQ-023 busy = (state != IDLE).

Reset
REQ-024 reset=1 forces immediately:
- state=IDLE, rr_ptr=0, grant=0, pkt_q=0, err_cnt=0;
- pop=0, push=0, D_push=0, busy=0.
REQ-025 Reset mid-transfer aborts the transfer with no further pop/push. A packet already popped is lost and not counted in err_cnt.

Configuration
REQ-026 Macro BUS_BCAST_EN defined: destination ID == broadcast is accepted.
- SEND waits until full is 0 on every drvrs index except grant.
- It then asserts push on all of those indices in one cycle.
REQ-027 BUS_BCAST_EN undefined: destination ID == broadcast is dropped per REQ-019.

Structure
REQ-028 Package bus_sched_pkg holds:
- state enum {IDLE, POP, SEND};
- ID_W = 8;
- default broadcast constant;
- function extracting the destination ID from a packet.
REQ-029 Sub-module rr_picker: combinational; inputs req and ptr, outputs winner index and valid; instantiated once.

Verification
REQ-030 pndng=4'b0100, D_pop[2]=16'h01AB, full=0 -> pop[2] one cycle, then push[1]=1 with D_push=16'h01AB one cycle later; err_cnt=0.
REQ-031 pndng=4'b1111 held, every packet addressed to a valid other driver -> grant sequence 0,1,2,3,0; each source popped once per round.
REQ-032 Source 0 packet 16'h03CD with full[3]=1 for 5 cycles -> SEND held 5 cycles with push=0, then push[3]=1 in the cycle after full[3] falls.
REQ-033 Source 1 packets 16'h0100 (self) and 16'h0700 (ID 7 with drvrs=4) -> no push for either; err_cnt=2.
REQ-034 Source 2 packet 16'hFF55 -> with BUS_BCAST_EN: push=4'b1011 in one cycle; without it: no push and err_cnt=1.
REQ-035 reset asserted in the POP cycle -> all outputs 0 immediately; next grant after release starts from index 0.
